// File: rtl/fwd_pkg.sv
// Shared types and default constants for the forwarding/hazard unit.
package fwd_pkg;

  localparam int unsigned FWD_N_DEFAULT            = 3;
  localparam int unsigned FWD_NB_REG_ADDR_DEFAULT  = 5;
  localparam int unsigned FWD_NB_REG_DEFAULT       = 32;
  localparam int unsigned FWD_NB_STALL_CNT_DEFAULT = 32;
  localparam int unsigned FWD_MAX_STALL_DEFAULT    = 15;

  // Select index width follows the default stage count.
  localparam int unsigned FWD_IDX_W = $clog2(FWD_N_DEFAULT);

  typedef enum logic [0:0] {
    ST_RUN,
    ST_STALL
  } fwd_state_e;

  typedef struct packed {
    logic                 valid;
    logic [FWD_IDX_W-1:0] idx;
  } fwd_sel_t;

  localparam fwd_sel_t FWD_SEL_NONE = '0;

endpackage

// File: rtl/fwd_select.sv
// Per-operand priority match, ready check and data mux.
// FWD_ZERO_REG_EN: when defined, source register 0 never matches.
module fwd_select
  import fwd_pkg::*;
#(
  parameter int unsigned N_FWD       = FWD_N_DEFAULT,
  parameter int unsigned NB_REG_ADDR = FWD_NB_REG_ADDR_DEFAULT,
  parameter int unsigned NB_REG      = FWD_NB_REG_DEFAULT
) (
  input  logic [NB_REG_ADDR-1:0]       src,
  input  logic                         use_op,
  input  logic                         early_use,
  input  logic [N_FWD*NB_REG_ADDR-1:0] rd_stage,
  input  logic [N_FWD-1:0]             we_stage,
  input  logic [N_FWD-1:0]             ready_stage,
  input  logic [N_FWD*NB_REG-1:0]      data_stage,
  input  fwd_sel_t                     sel_q,
  output fwd_sel_t                     sel,
  output logic                         hazard,
  output logic                         early_fwd,
  output logic [NB_REG-1:0]            early_data,
  output logic [NB_REG-1:0]            ex_data
);

  logic src_ok;
  logic sel_ready;

`ifdef FWD_ZERO_REG_EN
  assign src_ok = (src != '0);
`else
  assign src_ok = 1'b1;
`endif

  // Priority match: scan oldest to youngest so the lowest index wins.
  always_comb begin
    sel = FWD_SEL_NONE;
    for (int k = int'(N_FWD) - 1; k >= 0; k--) begin
      if (src_ok && use_op && we_stage[k] &&
          (rd_stage[k*NB_REG_ADDR +: NB_REG_ADDR] == src)) begin
        sel.valid = 1'b1;
        sel.idx   = FWD_IDX_W'(k);
      end
    end
  end

  // Ready lookup and data muxes for the live select and the registered one.
  always_comb begin
    sel_ready  = 1'b0;
    early_data = '0;
    ex_data    = '0;
    for (int unsigned k = 0; k < N_FWD; k++) begin
      if (sel.valid && (sel.idx == FWD_IDX_W'(k))) begin
        sel_ready  = ready_stage[k];
        early_data = data_stage[k*NB_REG +: NB_REG];
      end
      if (sel_q.valid && (sel_q.idx == FWD_IDX_W'(k))) begin
        ex_data = data_stage[k*NB_REG +: NB_REG];
      end
    end
  end

  // Only the selected (youngest) producer decides the hazard.
  assign hazard    = sel.valid & ~sel_ready;
  assign early_fwd = sel.valid & early_use & sel_ready;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard unit with stall counting.
// FWD_ZERO_REG_EN: when defined, register 0 never forwards or stalls.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned N_FWD        = FWD_N_DEFAULT,
  parameter int unsigned NB_REG_ADDR  = FWD_NB_REG_ADDR_DEFAULT,
  parameter int unsigned NB_REG       = FWD_NB_REG_DEFAULT,
  parameter int unsigned NB_STALL_CNT = FWD_NB_STALL_CNT_DEFAULT,
  parameter int unsigned MAX_STALL    = FWD_MAX_STALL_DEFAULT
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_valid,
  input  logic [NB_REG_ADDR-1:0]       i_rs,
  input  logic [NB_REG_ADDR-1:0]       i_rt,
  input  logic                         i_use_rs,
  input  logic                         i_use_rt,
  input  logic                         i_early_use,
  input  logic [N_FWD*NB_REG_ADDR-1:0] i_rd_stage,
  input  logic [N_FWD-1:0]             i_we_stage,
  input  logic [N_FWD-1:0]             i_ready_stage,
  input  logic [N_FWD*NB_REG-1:0]      i_data_stage,
  input  logic                         i_cnt_clear,
  output logic                         o_fwd_a,
  output logic                         o_fwd_b,
  output logic [NB_REG-1:0]            o_data_a,
  output logic [NB_REG-1:0]            o_data_b,
  output logic                         o_early_fwd_a,
  output logic                         o_early_fwd_b,
  output logic [NB_REG-1:0]            o_early_data_a,
  output logic [NB_REG-1:0]            o_early_data_b,
  output logic                         o_stall,
  output logic                         o_bubble,
  output logic [NB_STALL_CNT-1:0]      o_stall_cnt,
  output logic                         o_hazard_err
);

  localparam int unsigned NB_CONSEC = $clog2(MAX_STALL + 1);

  fwd_state_e              state_q, state_d;
  fwd_sel_t                sel_a, sel_b, sel_a_q, sel_b_q;
  logic                    hazard_a, hazard_b, hazard, stall;
  logic [NB_CONSEC-1:0]    consec_q, consec_d;
  logic                    err_q, err_d;
  logic [NB_STALL_CNT-1:0] cnt_q;

  fwd_select #(
    .N_FWD       (N_FWD),
    .NB_REG_ADDR (NB_REG_ADDR),
    .NB_REG      (NB_REG)
  ) u_sel_a (
    .src         (i_rs),
    .use_op      (i_use_rs),
    .early_use   (i_early_use),
    .rd_stage    (i_rd_stage),
    .we_stage    (i_we_stage),
    .ready_stage (i_ready_stage),
    .data_stage  (i_data_stage),
    .sel_q       (sel_a_q),
    .sel         (sel_a),
    .hazard      (hazard_a),
    .early_fwd   (o_early_fwd_a),
    .early_data  (o_early_data_a),
    .ex_data     (o_data_a)
  );

  fwd_select #(
    .N_FWD       (N_FWD),
    .NB_REG_ADDR (NB_REG_ADDR),
    .NB_REG      (NB_REG)
  ) u_sel_b (
    .src         (i_rt),
    .use_op      (i_use_rt),
    .early_use   (i_early_use),
    .rd_stage    (i_rd_stage),
    .we_stage    (i_we_stage),
    .ready_stage (i_ready_stage),
    .data_stage  (i_data_stage),
    .sel_q       (sel_b_q),
    .sel         (sel_b),
    .hazard      (hazard_b),
    .early_fwd   (o_early_fwd_b),
    .early_data  (o_early_data_b),
    .ex_data     (o_data_b)
  );

  assign hazard = hazard_a | hazard_b;

  // FSM next state and stall decision; nothing moves while i_valid is low.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (i_valid && hazard) begin
          stall   = 1'b1;
          state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (i_valid) begin
          stall = hazard;
          if (!hazard) state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    // Held low throughout reset even if a hazard is visible on the inputs.
    if (i_reset) stall = 1'b0;
  end

  assign o_stall  = stall;
  assign o_bubble = stall;

  // Consecutive-stall tracking; the error flag is sticky until reset.
  always_comb begin
    consec_d = consec_q;
    err_d    = err_q;
    if (stall) begin
      if (consec_q != NB_CONSEC'(MAX_STALL)) consec_d = consec_q + 1'b1;
      if (consec_q >= NB_CONSEC'(MAX_STALL - 1)) err_d = 1'b1;
    end else if (i_valid) begin
      consec_d = '0;
    end
  end

  // State, select records and counters.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_RUN;
      sel_a_q  <= FWD_SEL_NONE;
      sel_b_q  <= FWD_SEL_NONE;
      consec_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      consec_q <= consec_d;
      err_q    <= err_d;
      if (i_valid) begin
        // A stall loads "no forward" so the bubble in EX reads nothing.
        sel_a_q <= stall ? FWD_SEL_NONE : sel_a;
        sel_b_q <= stall ? FWD_SEL_NONE : sel_b;
      end
      if (i_cnt_clear) cnt_q <= '0;
      else if (stall)  cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_fwd_a      = sel_a_q.valid;
  assign o_fwd_b      = sel_b_q.valid;
  assign o_stall_cnt  = cnt_q;
  assign o_hazard_err = err_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit (default parameters).
// FWD_ZERO_REG_EN selects the expected register-0 behaviour.
module tb_fwd_hazard_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid;
  logic [4:0]  rs, rt;
  logic        use_rs, use_rt, early_use, cnt_clear;
  logic [14:0] rd_stage;
  logic [2:0]  we_stage, ready_stage;
  logic [95:0] data_stage;
  logic        fwd_a, fwd_b, early_fwd_a, early_fwd_b, stall, bubble, hazard_err;
  logic [31:0] data_a, data_b, early_data_a, early_data_b, stall_cnt;

  logic [4:0]  rd [3];
  logic        we [3];
  logic        rdy[3];
  logic [31:0] dat[3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  // Pack per-stage stimulus into the flat vectors.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rd_stage[k*5 +: 5]    = rd[k];
      we_stage[k]           = we[k];
      ready_stage[k]        = rdy[k];
      data_stage[k*32 +: 32] = dat[k];
    end
  end

  fwd_hazard_unit dut (
    .i_clock        (clock),
    .i_reset        (reset),
    .i_valid        (valid),
    .i_rs           (rs),
    .i_rt           (rt),
    .i_use_rs       (use_rs),
    .i_use_rt       (use_rt),
    .i_early_use    (early_use),
    .i_rd_stage     (rd_stage),
    .i_we_stage     (we_stage),
    .i_ready_stage  (ready_stage),
    .i_data_stage   (data_stage),
    .i_cnt_clear    (cnt_clear),
    .o_fwd_a        (fwd_a),
    .o_fwd_b        (fwd_b),
    .o_data_a       (data_a),
    .o_data_b       (data_b),
    .o_early_fwd_a  (early_fwd_a),
    .o_early_fwd_b  (early_fwd_b),
    .o_early_data_a (early_data_a),
    .o_early_data_b (early_data_b),
    .o_stall        (stall),
    .o_bubble       (bubble),
    .o_stall_cnt    (stall_cnt),
    .o_hazard_err   (hazard_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_stage(input int k, input logic [4:0] r, input logic w, input logic y,
                           input logic [31:0] d);
    rd[k] = r; we[k] = w; rdy[k] = y; dat[k] = d;
  endtask

  task automatic clear_stages();
    for (int k = 0; k < 3; k++) set_stage(k, 5'd0, 1'b0, 1'b1, 32'h0);
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; rs = '0; rt = '0; use_rs = 1'b0; use_rt = 1'b0;
    early_use = 1'b0; cnt_clear = 1'b0;
    clear_stages();
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_eq("rst_fwd_a", {31'd0, fwd_a}, 32'd0);
    check_eq("rst_data_a", data_a, 32'd0);
    check_eq("rst_cnt", stall_cnt, 32'd0);
    check_eq("rst_err", {31'd0, hazard_err}, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);

    // Youngest producer wins over an older one with the same rd.
    valid = 1'b1; use_rs = 1'b1; rs = 5'd5;
    set_stage(0, 5'd5, 1'b1, 1'b1, 32'hAAAA);
    set_stage(2, 5'd5, 1'b1, 1'b1, 32'h1111);
    #1;
    check_eq("prio_stall", {31'd0, stall}, 32'd0);
    tick();
    check_eq("prio_fwd_a", {31'd0, fwd_a}, 32'd1);
    check_eq("prio_data_a", data_a, 32'hAAAA);
    check_eq("prio_fwd_b", {31'd0, fwd_b}, 32'd0);
    check_eq("prio_data_b", data_b, 32'd0);

    // Load-use on rt: one stall, then forward from stage 1.
    clear_stages();
    use_rs = 1'b0; use_rt = 1'b1; rt = 5'd7;
    set_stage(0, 5'd7, 1'b1, 1'b0, 32'hDEAD);
    #1;
    check_eq("lu_stall", {31'd0, stall}, 32'd1);
    check_eq("lu_bubble", {31'd0, bubble}, 32'd1);
    tick();
    check_eq("lu_bubble_fwd_b", {31'd0, fwd_b}, 32'd0);
    check_eq("lu_cnt1", stall_cnt, 32'd1);
    clear_stages();
    set_stage(1, 5'd7, 1'b1, 1'b1, 32'h55);
    #1;
    check_eq("lu_nostall", {31'd0, stall}, 32'd0);
    tick();
    check_eq("lu_fwd_b", {31'd0, fwd_b}, 32'd1);
    check_eq("lu_data_b", data_b, 32'h55);
    check_eq("lu_cnt_hold", stall_cnt, 32'd1);

    // Early branch operand resolved in ID from stage 1.
    clear_stages();
    use_rt = 1'b0; use_rs = 1'b1; rs = 5'd3; early_use = 1'b1;
    set_stage(1, 5'd3, 1'b1, 1'b1, 32'h10);
    #1;
    check_eq("early_fwd_a", {31'd0, early_fwd_a}, 32'd1);
    check_eq("early_data_a", early_data_a, 32'h10);
    check_eq("early_fwd_b", {31'd0, early_fwd_b}, 32'd0);
    check_eq("early_nostall", {31'd0, stall}, 32'd0);
    rdy[1] = 1'b0;
    #1;
    check_eq("early_unready_fwd", {31'd0, early_fwd_a}, 32'd0);
    check_eq("early_unready_stall", {31'd0, stall}, 32'd1);
    tick();
    rdy[1] = 1'b1;
    #1;
    check_eq("early_ready_fwd", {31'd0, early_fwd_a}, 32'd1);
    check_eq("early_ready_stall", {31'd0, stall}, 32'd0);
    tick();
    check_eq("early_cnt", stall_cnt, 32'd2);

    // valid low: hazard visible but no stall, no count, select holds.
    rdy[1] = 1'b0; valid = 1'b0;
    #1;
    check_eq("inv_stall", {31'd0, stall}, 32'd0);
    tick();
    check_eq("inv_cnt", stall_cnt, 32'd2);
    check_eq("inv_fwd_hold", {31'd0, fwd_a}, 32'd1);

    // Hold a hazard for MAX_STALL cycles.
    valid = 1'b1; early_use = 1'b0; rs = 5'd9;
    clear_stages();
    set_stage(0, 5'd9, 1'b1, 1'b0, 32'h0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 14) check_eq("err_before", {31'd0, hazard_err}, 32'd0);
    end
    check_eq("err_at_15", {31'd0, hazard_err}, 32'd1);
    check_eq("long_cnt", stall_cnt, 32'd17);
    check_eq("long_still_stall", {31'd0, stall}, 32'd1);
    rdy[0] = 1'b1;
    tick();
    check_eq("err_sticky", {31'd0, hazard_err}, 32'd1);
    // Clear wins over a simultaneous stall.
    rdy[0] = 1'b0; cnt_clear = 1'b1;
    #1;
    check_eq("clr_stall", {31'd0, stall}, 32'd1);
    tick();
    check_eq("clr_cnt", stall_cnt, 32'd0);
    cnt_clear = 1'b0;
    tick();
    check_eq("post_clr_cnt", stall_cnt, 32'd1);

    // Asynchronous reset mid-stall.
    #2 reset = 1'b1;
    #1;
    check_eq("arst_stall", {31'd0, stall}, 32'd0);
    check_eq("arst_bubble", {31'd0, bubble}, 32'd0);
    check_eq("arst_fwd_a", {31'd0, fwd_a}, 32'd0);
    check_eq("arst_data_b", data_b, 32'd0);
    check_eq("arst_cnt", stall_cnt, 32'd0);
    check_eq("arst_err", {31'd0, hazard_err}, 32'd0);
    reset = 1'b0;
    set_stage(0, 5'd9, 1'b1, 1'b1, 32'h9999);
    #1;
    check_eq("arst_rel_stall", {31'd0, stall}, 32'd0);
    tick();
    check_eq("arst_rel_cnt", stall_cnt, 32'd0);
    check_eq("arst_rel_fwd_a", {31'd0, fwd_a}, 32'd1);
    check_eq("arst_rel_data_a", data_a, 32'h9999);

    // Register 0 as source.
    rs = 5'd0;
    clear_stages();
    set_stage(0, 5'd0, 1'b1, 1'b1, 32'h77);
    tick();
`ifdef FWD_ZERO_REG_EN
    check_eq("zero_fwd_a", {31'd0, fwd_a}, 32'd0);
    check_eq("zero_data_a", data_a, 32'd0);
`else
    check_eq("zero_fwd_a", {31'd0, fwd_a}, 32'd1);
    check_eq("zero_data_a", data_a, 32'h77);
`endif
    rdy[0] = 1'b0;
    #1;
`ifdef FWD_ZERO_REG_EN
    check_eq("zero_stall", {31'd0, stall}, 32'd0);
`else
    check_eq("zero_stall", {31'd0, stall}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised operand-forwarding and load-use hazard unit for the MIPS pipeline, successor to the two-source (EX/MEM) shortcircuit unit. It compares the ID-stage source registers against N_FWD downstream producer stages, selects the youngest valid producer, and supplies operands to EX on a registered select and to ID for early-resolved branches and jump-register instructions. When the selected producer's result is not yet available, it stalls ID, inserts a bubble into EX, and counts the stall cycles.

## Interface
- N_FWD, 3: number of producer stages; index 0 is the youngest (EX output), higher indices are older.
- NB_REG_ADDR, 5: register address width.
- NB_REG, 32: data width.
- NB_STALL_CNT, 32: width of the stall performance counter.
- MAX_STALL, 15: maximum consecutive stall cycles before the error flag is raised (at least 1).
- i_clock  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  pipeline advance enable.
- i_rs, i_rt  in  NB_REG_ADDR each  ID-stage sources.
- i_use_rs, i_use_rt  in  1 each  operand is actually read.
- i_early_use  in  1  ID instruction resolves in ID (branch or jr).
- i_rd_stage  in  N_FWD*NB_REG_ADDR  destination per stage; stage k occupies bits [k*NB_REG_ADDR +: NB_REG_ADDR].
- i_we_stage  in  N_FWD  stage writes back.
- i_ready_stage  in  N_FWD  stage result is present on i_data_stage.
- i_data_stage  in  N_FWD*NB_REG  result data per stage.
- i_cnt_clear  in  1  synchronous clear of the stall counter.
- o_fwd_a, o_fwd_b  out  1 each  registered EX operand-mux enable.
- o_data_a, o_data_b  out  NB_REG each  EX forwarded data.
- o_early_fwd_a, o_early_fwd_b  out  1 each  ID operand-mux enable (combinational).
- o_early_data_a, o_early_data_b  out  NB_REG each  ID forwarded data (combinational).
- o_stall  out  1  hold PC and IF/ID.
- o_bubble  out  1  zero the ID/EX control.
- o_stall_cnt  out  NB_STALL_CNT  total stall cycles.
- o_hazard_err  out  1  sticky flag: stall exceeded MAX_STALL.

## Operation
- Match, per operand: m[k] = (src == rd[k]) & we[k] & use. The select is the lowest k with m[k] set; no match means no forward.
- Hazard: the selected stage has ready = 0. Only the selected stage is checked. An older ready stage never masks a younger, unready one.
- Early-use gating: o_early_fwd_x = match & i_early_use & ready. o_early_data_x = i_data_stage[sel], evaluated in the same cycle.
- EX path: on i_valid & ~o_stall, the select registers capture {match, k}. On o_stall they capture "no forward" (the bubble). On ~i_valid they hold.
- o_data_x = i_data_stage[sel_reg] in the following cycle. By design, stage index k at t+1 carries the result of the instruction that matched at index k at t. Integration wires the data vector to meet this.
- o_data_x is zero when o_fwd_x = 0.
- FSM RUN: if the hazard is present and i_valid is set, go to STALL; o_stall and o_bubble are asserted combinationally in the same cycle.
- FSM STALL: o_stall = o_bubble = hazard. Return to RUN when the hazard clears. A consecutive-stall counter increments each stalled cycle.
- When the consecutive-stall count reaches MAX_STALL, o_hazard_err is set and remains set until reset. The stall continues.
- o_stall_cnt increments on every cycle with o_stall = 1 and wraps at 2^NB_STALL_CNT.
- If i_cnt_clear and a stall occur in the same cycle, the clear wins and the counter becomes 0.
- With i_valid = 0: no FSM transition, no counting, o_stall = 0.
- Reset (asynchronous, at any time, including mid-stall):
  - FSM returns to RUN.
  - Select registers are cleared: o_fwd_a = o_fwd_b = 0, o_data_a = o_data_b = 0.
  - o_stall_cnt = 0, o_hazard_err = 0.
  - o_stall and o_bubble are 0 while reset is high.

## Timing
- Stall, bubble and early-forward outputs are combinational from the inputs plus state, with 0-cycle latency.
- The EX forward enable is registered, with 1-cycle latency.
- A load in stage 0 with ready = 0 produces one stall cycle. The operand is forwarded from stage 1 in the next cycle.
- With i_early_use set, the stall lasts until the selected stage is ready.

## Configuration
- FWD_ZERO_REG_EN defined: source register 0 never matches. It always reads zero, never stalls, and never forwards.
- FWD_ZERO_REG_EN undefined: register 0 is compared like any other register. Correctness then relies on decode clearing the write enable for rd = 0.

## Structure
- The shared package `fwd_pkg` holds:
  - the FSM state encoding (ST_RUN, ST_STALL),
  - the select-record type {valid, index of $clog2(N_FWD) bits},
  - the default constants.
- One sub-module, `fwd_select`, handles a single operand: priority match, ready check and mux. It is instantiated once for A and once for B.

## Test plan
- rs = 5, stage 0 (rd = 5, we = 1, ready = 1, data = 0xAAAA) and stage 2 (rd = 5, data = 0x1111) -> o_fwd_a = 1 the next cycle, o_data_a = 0xAAAA (youngest producer wins).
- Load-use: rt = 7, stage 0 (rd = 7, ready = 0) -> o_stall = o_bubble = 1 for one cycle. The next cycle has stage 1 (rd = 7, ready = 1, 0x55) -> o_fwd_b = 1, o_data_b = 0x55, o_stall_cnt = 1.
- Early branch: i_early_use = 1, rs = 3, stage 1 ready with 0x10 -> o_early_fwd_a = 1 and o_early_data_a = 0x10 in the same cycle, with no stall.
- Hold the hazard for MAX_STALL = 15 cycles -> o_hazard_err rises on cycle 15 and stays high after the hazard clears. i_cnt_clear then zeroes the counter.
- Assert reset asynchronously in the middle of STALL -> all outputs are 0 immediately. After release the FSM is in RUN and o_stall_cnt = 0.
- rs = 0 with stage 0 (rd = 0, we = 1): with FWD_ZERO_REG_EN defined -> o_fwd_a = 0. Undefined -> o_fwd_a = 1.
